// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the round-robin memory arbiter.
// WIDTH/ADDR_WIDTH defaults track the single-port mem instance being shared.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam int NUM_REQ_DEF    = 3;
    localparam int WIDTH_DEF      = 16;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int TIMEOUT_DEF    = 64;

    // Pointer width never drops to zero, even for degenerate requester counts.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
// Kept standalone so coverage models can reuse the exact same selection rule.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               found_o
);

    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] oh_rot;

    // Rotate so the pointer position lands at bit 0, pick lowest, rotate back.
    assign rot = NUM_REQ'({req_i, req_i} >> ptr_i);

    always_comb begin
        oh_rot = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                oh_rot    = '0;
                oh_rot[j] = 1'b1;
            end
        end
    end

    assign gnt_o   = NUM_REQ'(({oh_rot, oh_rot} << ptr_i) >> NUM_REQ);
    assign found_o = |req_i;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port mem between NUM_REQ requesters.
// IDLE arbitrates, BUSY holds the latched request on mem, RESP returns the ready pulse.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int WIDTH      = WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_wr_rd_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*WIDTH-1:0]      req_wr_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [WIDTH-1:0]              rd_data_o,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic                          timeout_o,
    output logic                          mem_valid_o,
    output logic                          mem_wr_rd_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic [WIDTH-1:0]              mem_wr_data_o,
    input  logic                          mem_ready_i,
    input  logic [WIDTH-1:0]              mem_rd_data_i
);

    localparam int PTR_W = ptr_width(NUM_REQ);
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    // Handshake (both directions): a transfer happens on a rising edge where
    // valid and ready are both high; valid stays asserted with stable fields until then.

    arb_state_e              state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic                    wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]        wdata_q, wdata_d;
    logic                    valid_q, valid_d;
    logic [NUM_REQ-1:0]      ready_q, ready_d;
    logic [WIDTH-1:0]        rd_data_q, rd_data_d;
    logic                    timeout_q, timeout_d;
    logic [WD_W-1:0]         wd_cnt_q, wd_cnt_d;

    logic [NUM_REQ-1:0]      win_oh;
    logic                    win_found;
    logic [PTR_W-1:0]        win_idx;
    logic                    win_wr;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [WIDTH-1:0]        win_data;
    logic                    handshake;
    logic                    wd_expire;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .gnt_o   (win_oh),
        .found_o (win_found)
    );

    always_comb begin
        win_idx  = '0;
        win_wr   = 1'b0;
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                win_idx  = PTR_W'(i);
                win_wr   = req_wr_rd_i[i];
                win_addr = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_data = req_wr_data_i[i*WIDTH +: WIDTH];
            end
        end
    end

    assign handshake = valid_q && mem_ready_i;
    assign wd_expire = (TIMEOUT != 0) && (wd_cnt_q == WD_LAST);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        valid_d   = valid_q;
        ready_d   = '0;
        rd_data_d = rd_data_q;
        timeout_d = 1'b0;
        wd_cnt_d  = wd_cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d  = BUSY;
                    gnt_d    = win_oh;
                    wr_d     = win_wr;
                    addr_d   = win_addr;
                    wdata_d  = win_data;
                    valid_d  = 1'b1;
                    wd_cnt_d = '0;
                    ptr_d    = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
                end
            end
            BUSY: begin
                wd_cnt_d = wd_cnt_q + WD_W'(1);
                // A handshake on the expiry edge still counts as a normal completion.
                if (handshake) begin
                    valid_d   = 1'b0;
                    ready_d   = gnt_q;
                    rd_data_d = wr_q ? '0 : mem_rd_data_i;
                    state_d   = RESP;
                end else if (wd_expire) begin
                    valid_d   = 1'b0;
                    ready_d   = gnt_q;
                    rd_data_d = '0;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            valid_q   <= 1'b0;
            ready_q   <= '0;
            rd_data_q <= '0;
            timeout_q <= 1'b0;
            wd_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
            rd_data_q <= rd_data_d;
            timeout_q <= timeout_d;
            wd_cnt_q  <= wd_cnt_d;
        end
    end

    assign req_ready_o   = ready_q;
    assign rd_data_o     = rd_data_q;
    assign gnt_o         = gnt_q;
    assign timeout_o     = timeout_q;
    assign mem_valid_o   = valid_q;
    assign mem_wr_rd_o   = wr_q;
    assign mem_addr_o    = addr_q;
    assign mem_wr_data_o = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction table plus hand-written corner sequences.
// A small behavioural mem answers with a per-transaction ready latency.
module tb_mem_arbiter;

  localparam int NR = 3;
  localparam int W  = 16;
  localparam int AW = 4;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req_valid_i;
  logic [NR-1:0]   req_wr_rd_i;
  logic [NR*AW-1:0] req_addr_i;
  logic [NR*W-1:0] req_wr_data_i;
  logic [NR-1:0]   req_ready_o;
  logic [W-1:0]    rd_data_o;
  logic [NR-1:0]   gnt_o;
  logic            timeout_o;
  logic            mem_valid_o;
  logic            mem_wr_rd_o;
  logic [AW-1:0]   mem_addr_o;
  logic [W-1:0]    mem_wr_data_o;
  logic            mem_ready_i;
  logic [W-1:0]    mem_rd_data_i;

  mem_arbiter #(
    .NUM_REQ    (NR),
    .WIDTH      (W),
    .ADDR_WIDTH (AW),
    .TIMEOUT    (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .req_wr_rd_i   (req_wr_rd_i),
    .req_addr_i    (req_addr_i),
    .req_wr_data_i (req_wr_data_i),
    .req_ready_o   (req_ready_o),
    .rd_data_o     (rd_data_o),
    .gnt_o         (gnt_o),
    .timeout_o     (timeout_o),
    .mem_valid_o   (mem_valid_o),
    .mem_wr_rd_o   (mem_wr_rd_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wr_data_o (mem_wr_data_o),
    .mem_ready_i   (mem_ready_i),
    .mem_rd_data_i (mem_rd_data_i)
  );

  typedef struct {
    logic [NR-1:0]    valid;
    logic [NR-1:0]    wr;
    logic [NR*AW-1:0] addr;
    logic [NR*W-1:0]  data;
    int               lat;
    logic [NR-1:0]    exp_gnt;
    logic [AW-1:0]    exp_addr;
    logic [W-1:0]     exp_rd;
    logic             exp_to;
    int               exp_vcyc;
  } vec_t;

  int        n_cmp;
  int        n_fail;
  int        mem_lat;
  int        busy_cyc;
  logic [W-1:0] mem_arr [16];
  vec_t      tbl [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded, required completion");
    $fatal(1, "simulation time limit");
  end

  // Behavioural mem: ready pulses in valid cycle mem_lat+1; mem_lat < 0 never answers.
  initial begin
    mem_ready_i   = 1'b0;
    mem_rd_data_i = 16'hDEAD;
    busy_cyc      = 0;
    for (int i = 0; i < 16; i++) mem_arr[i] = '0;
    forever begin
      @(negedge clk);
      if (mem_valid_o) busy_cyc++;
      else busy_cyc = 0;
      if (mem_valid_o && mem_lat >= 0 && busy_cyc == mem_lat + 1) begin
        mem_ready_i = 1'b1;
        if (mem_wr_rd_o) begin
          mem_arr[mem_addr_o] = mem_wr_data_o;
          mem_rd_data_i = 16'hDEAD;
        end else begin
          mem_rd_data_i = mem_arr[mem_addr_o];
        end
      end else begin
        mem_ready_i   = 1'b0;
        mem_rd_data_i = 16'hDEAD;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    req_valid_i   = '0;
    req_wr_rd_i   = '0;
    req_addr_i    = '0;
    req_wr_data_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    int  vcyc;
    bit  seen;
    bit  got;
    req_valid_i   = v.valid;
    req_wr_rd_i   = v.wr;
    req_addr_i    = v.addr;
    req_wr_data_i = v.data;
    mem_lat       = v.lat;
    vcyc = 0;
    seen = 1'b0;
    got  = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (c == 0) check("grant_latency", mem_valid_o, 1'b1);
      if (mem_valid_o) begin
        vcyc++;
        if (!seen) begin
          seen = 1'b1;
          check("busy_gnt", gnt_o, v.exp_gnt);
          check("mem_addr", mem_addr_o, v.exp_addr);
        end
      end
      if (req_ready_o != '0 || timeout_o) got = 1'b1;
    end
    check("ready_seen", got, 1'b1);
    check("ready_pulse", req_ready_o, v.exp_gnt);
    check("resp_gnt", gnt_o, v.exp_gnt);
    check("rd_data", rd_data_o, v.exp_rd);
    check("timeout", timeout_o, v.exp_to);
    check("valid_cycles", vcyc, v.exp_vcyc);
    @(negedge clk);
    check("ready_cleared", req_ready_o, '0);
    check("timeout_cleared", timeout_o, 1'b0);
    check("gnt_cleared", gnt_o, '0);
  endtask

  initial begin
    vec_t v;
    int   c;
    n_cmp   = 0;
    n_fail  = 0;
    mem_lat = -1;

    tbl.push_back('{3'b001, 3'b001, 12'h003, 48'h0000_0000_A5A5, 2, 3'b001, 4'h3, 16'h0000, 1'b0, 3});
    tbl.push_back('{3'b010, 3'b000, 12'h030, 48'h0,              1, 3'b010, 4'h3, 16'hA5A5, 1'b0, 2});
    tbl.push_back('{3'b111, 3'b101, 12'h635, 48'h2222_0000_1111, 0, 3'b001, 4'h5, 16'h0000, 1'b0, 1});
    tbl.push_back('{3'b111, 3'b101, 12'h635, 48'h2222_0000_1111, 1, 3'b010, 4'h3, 16'hA5A5, 1'b0, 2});
    tbl.push_back('{3'b111, 3'b101, 12'h635, 48'h2222_0000_1111, 2, 3'b100, 4'h6, 16'h0000, 1'b0, 3});
    tbl.push_back('{3'b111, 3'b101, 12'h635, 48'h2222_0000_1111, 3, 3'b001, 4'h5, 16'h0000, 1'b0, 4});
    tbl.push_back('{3'b111, 3'b101, 12'h635, 48'h2222_0000_1111, 0, 3'b010, 4'h3, 16'hA5A5, 1'b0, 1});
    tbl.push_back('{3'b111, 3'b101, 12'h635, 48'h2222_0000_1111, 1, 3'b100, 4'h6, 16'h0000, 1'b0, 2});
    tbl.push_back('{3'b110, 3'b000, 12'h650, 48'h0,              0, 3'b010, 4'h5, 16'h1111, 1'b0, 1});
    tbl.push_back('{3'b110, 3'b000, 12'h650, 48'h0,              2, 3'b100, 4'h6, 16'h2222, 1'b0, 3});
    tbl.push_back('{3'b110, 3'b000, 12'h650, 48'h0,              1, 3'b010, 4'h5, 16'h1111, 1'b0, 2});
    tbl.push_back('{3'b110, 3'b000, 12'h650, 48'h0,              0, 3'b100, 4'h6, 16'h2222, 1'b0, 1});
    tbl.push_back('{3'b001, 3'b000, 12'h003, 48'h0,             -1, 3'b001, 4'h3, 16'h0000, 1'b1, 8});
    tbl.push_back('{3'b001, 3'b000, 12'h003, 48'h0,              7, 3'b001, 4'h3, 16'hA5A5, 1'b0, 8});

    // Reset state
    rst           = 1'b1;
    req_valid_i   = '0;
    req_wr_rd_i   = '0;
    req_addr_i    = '0;
    req_wr_data_i = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready_o, '0);
    check("rst_rd_data", rd_data_o, '0);
    check("rst_gnt", gnt_o, '0);
    check("rst_timeout", timeout_o, 1'b0);
    check("rst_mem_valid", mem_valid_o, 1'b0);
    check("rst_mem_wr_rd", mem_wr_rd_o, 1'b0);
    check("rst_mem_addr", mem_addr_o, '0);
    check("rst_mem_wr_data", mem_wr_data_o, '0);
    rst = 1'b0;

    // Table: write/read-back, fairness after reset, two-requester rotation, watchdog
    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 2) do_reset();
      run_txn(tbl[i]);
    end

    // Early drop: req2 withdraws after one BUSY cycle; latched fields must persist
    req_valid_i   = 3'b100;
    req_wr_rd_i   = 3'b100;
    req_addr_i    = 12'h900;
    req_wr_data_i = 48'h5A5A_0000_0000;
    mem_lat       = 3;
    @(negedge clk);
    check("drop_valid", mem_valid_o, 1'b1);
    check("drop_gnt", gnt_o, 3'b100);
    req_valid_i   = '0;
    req_addr_i    = '0;
    req_wr_data_i = '1;
    c = 0;
    while (req_ready_o == '0 && c < 40) begin
      if (mem_valid_o) begin
        check("drop_addr_held", mem_addr_o, 4'h9);
        check("drop_data_held", mem_wr_data_o, 16'h5A5A);
      end
      @(negedge clk);
      c++;
    end
    check("drop_ready", req_ready_o, 3'b100);
    check("drop_rd_data", rd_data_o, 16'h0000);
    @(negedge clk);
    v = '{3'b001, 3'b000, 12'h009, 48'h0, 0, 3'b001, 4'h9, 16'h5A5A, 1'b0, 1};
    run_txn(v);

    // Reset while BUSY: req1 wins (ptr moves to 2), then reset must return ptr to 0
    req_valid_i   = 3'b010;
    req_wr_rd_i   = 3'b000;
    req_addr_i    = 12'h010;
    req_wr_data_i = '0;
    mem_lat       = -1;
    @(negedge clk);
    check("midrst_busy_gnt", gnt_o, 3'b010);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", mem_valid_o, 1'b0);
    check("midrst_gnt", gnt_o, '0);
    check("midrst_ready", req_ready_o, '0);
    check("midrst_timeout", timeout_o, 1'b0);
    rst = 1'b0;
    v = '{3'b111, 3'b000, 12'h333, 48'h0, 0, 3'b001, 4'h3, 16'hA5A5, 1'b0, 1};
    run_txn(v);

    req_valid_i = '0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
